// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants for the RAM-backed FIFO controller.
// Pointer width is the RAM address width plus one wrap flag bit.
package ram_fifo_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int PTR_WIDTH      = DEF_ADDR_WIDTH + 1;

  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for ram_fifo_ctrl.
// Signal names are seen from the FIFO side (_i into the FIFO, _o out of it).
interface ram_fifo_ctrl_if
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );
endinterface

// File: rtl/dual_port_ram.sv
// Dual-port RAM: synchronous write port, asynchronous (combinational) read port.
// Contents are never cleared; reset is not connected.
module dual_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  i_write_en,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_read_addr,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_write_en) r_mem[i_write_addr] <= i_data;
  end

  assign o_data = r_mem[i_read_addr];
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external async-read dual-port RAM, with a registered
// output word in front of the consumer (capacity = RAM depth + 1).
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_fifo_ctrl_if.slave        bus,
  output logic                  ram_write_en_o,
  output logic [ADDR_WIDTH-1:0] ram_write_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_read_en_o,
  output logic [ADDR_WIDTH-1:0] ram_read_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_data_p1;
  logic                  r_vld_p1;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  // Flags come only from registered pointers, so ready_o never sees ready_i.
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = bus.valid_i && !w_full;
  assign w_pop   = !w_empty && (!r_vld_p1 || bus.ready_i);

  assign bus.ready_o      = !w_full;
  assign bus.data_o       = r_data_p1;
  assign bus.valid_o      = r_vld_p1;
  assign ram_write_en_o   = w_push;
  assign ram_write_addr_o = r_wr_ptr[PW-2:0];
  assign ram_data_o       = bus.data_i;
  assign ram_read_en_o    = w_pop;
  assign ram_read_addr_o  = r_rd_ptr[PW-2:0];
  assign count_o          = r_wr_ptr - r_rd_ptr;
  assign full_o           = w_full;
  assign empty_o          = w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Output stage p1: captures the RAM read word on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else if (w_pop) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= ram_data_i;
    end else if (r_vld_p1 && bus.ready_i) begin
      r_vld_p1  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with dual_port_ram wired beside it.
module tb_ram_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus();
  logic          ram_we, ram_re, full, empty;
  logic [AW-1:0] ram_wa, ram_ra;
  logic [DW-1:0] ram_wd, ram_rd;
  logic [AW:0]   count;

  int checks = 0;
  int failures = 0;
  int n_rd = 0;
  logic [DW-1:0] sb_q[$];
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_data;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_write_en_o(ram_we), .ram_write_addr_o(ram_wa), .ram_data_o(ram_wd),
    .ram_read_en_o(ram_re), .ram_read_addr_o(ram_ra), .ram_data_i(ram_rd),
    .count_o(count), .full_o(full), .empty_o(empty)
  );

  dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram (
    .clk(clk), .i_write_en(ram_we), .i_write_addr(ram_wa), .i_data(ram_wd),
    .i_read_addr(ram_ra), .o_data(ram_rd)
  );

  // One cycle: observe handshakes with settled inputs, then advance to the next negedge.
  task automatic tick();
    logic [DW-1:0] exp;
    #1;
    if (!rst) begin
      if (hold_pending) begin
        checks++;
        if (bus.valid_o !== 1'b1 || bus.data_o !== hold_data) begin
          failures++;
          $display("FAIL hold_stable: valid_o=%0b data_o=%h required valid_o=1 data_o=%h",
                   bus.valid_o, bus.data_o, hold_data);
        end
      end
      hold_pending = (bus.valid_o === 1'b1) && (bus.ready_i === 1'b0);
      hold_data    = bus.data_o;
      if (bus.valid_i && bus.ready_o) sb_q.push_back(bus.data_i);
      if (bus.valid_o && bus.ready_i) begin
        n_rd++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow: got data_o=%h required no output", bus.data_o);
        end else begin
          exp = sb_q.pop_front();
          if (bus.data_o !== exp) begin
            failures++;
            $display("FAIL sb_data: got %h required %h", bus.data_o, exp);
          end
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
    checks++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== '0 || count !== '0 || empty !== 1'b1 ||
        bus.ready_o !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%0b data=%h count=%0d empty=%0b ready=%0b full=%0b required 0 0 0 1 1 0",
               bus.valid_o, bus.data_o, count, empty, bus.ready_o, full);
    end
  endtask

  task automatic test_single();
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hA5A5_0001;
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_wa !== 3'd0 || ram_wd !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL single_ram_write: we=%0b addr=%0d data=%h required 1 0 a5a50001", ram_we, ram_wa, ram_wd);
    end
    tick();
    bus.valid_i = 1'b0;
    checks++;
    if (count !== 4'd1 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_edge_n: count=%0d valid=%0b required count=1 valid=0", count, bus.valid_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 32'hA5A5_0001 || count !== 4'd0) begin
      failures++;
      $display("FAIL single_edge_n1: valid=%0b data=%h count=%0d required 1 a5a50001 0",
               bus.valid_o, bus.data_o, count);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL single_edge_n2: valid=%0b empty=%0b required valid=0 empty=1", bus.valid_o, empty);
    end
  endtask

  task automatic test_fill();
    int   acc_n;
    logic acc;
    acc_n = 0;
    bus.ready_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = acc_n;
      acc = bus.ready_o;
      tick();
      if (acc) acc_n++;
    end
    checks++;
    if (acc_n != 9) begin
      failures++;
      $display("FAIL fill_accepted: got %0d required 9", acc_n);
    end
    checks++;
    if (full !== 1'b1 || bus.ready_o !== 1'b0 || count !== 4'd8 || bus.valid_o !== 1'b1 || bus.data_o !== 32'd0) begin
      failures++;
      $display("FAIL fill_full: full=%0b ready=%0b count=%0d valid=%0b data=%h required 1 0 8 1 0",
               full, bus.ready_o, count, bus.valid_o, bus.data_o);
    end
    bus.ready_i = 1'b1;
    n_rd = 0;
    for (int c = 0; c < 40; c++) begin
      acc = bus.valid_i && bus.ready_o;
      tick();
      if (acc) bus.valid_i = 1'b0;
      if (!bus.valid_i && sb_q.size() == 0) break;
    end
    checks++;
    if (n_rd != 10 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL fill_drain: delivered=%0d left=%0d required 10 0", n_rd, sb_q.size());
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] d;
    logic          acc;
    d = 32'h100;
    n_rd = 0;
    tick();
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.data_i = d;
      checks++;
      if (count > 4'd1 || (k >= 2 && bus.valid_o !== 1'b1)) begin
        failures++;
        $display("FAIL stream_cycle%0d: count=%0d valid=%0b required count<=1 valid=%0b",
                 k, count, bus.valid_o, (k >= 2));
      end
      acc = bus.ready_o;
      tick();
      if (acc) d++;
    end
    bus.valid_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (sb_q.size() == 0 && !bus.valid_o) break;
      tick();
    end
    checks++;
    if (n_rd != 40 || d != 32'h128) begin
      failures++;
      $display("FAIL stream_total: delivered=%0d accepted=%0d required 40 40", n_rd, d - 32'h100);
    end
  endtask

  task automatic test_backpressure();
    int   sent;
    logic acc;
    sent = 0;
    n_rd = 0;
    for (int c = 0; c < 6000 && sent < 1000; c++) begin
      bus.valid_i = ($urandom_range(0, 9) < 7);
      bus.data_i  = $urandom;
      bus.ready_i = $urandom_range(0, 1);
      acc = bus.valid_i && bus.ready_o;
      tick();
      if (acc) sent++;
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (sb_q.size() == 0 && !bus.valid_o) break;
      tick();
    end
    checks++;
    if (sent != 1000 || n_rd != 1000 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL backpressure_total: sent=%0d delivered=%0d left=%0d required 1000 1000 0",
               sent, n_rd, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = 32'hDEAD_0000 + i;
      tick();
    end
    bus.valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    checks++;
    if (bus.valid_o !== 1'b0 || count !== '0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_state: valid=%0b count=%0d empty=%0b required 0 0 1", bus.valid_o, count, empty);
    end
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'h0000_1234;
    tick();
    bus.valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.valid_o === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (bus.data_o !== 32'h0000_1234) begin
          failures++;
          $display("FAIL reset_mid_first: got %h required 00001234", bus.data_o);
        end
      end
      tick();
    end
    checks++;
    if (!seen || sb_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_timeout: seen=%0b left=%0d required 1 0", seen, sb_q.size());
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
